// File: rtl/hhmm_clock_ctrl_if.sv
// -----------------------------------------------------------------------------
// hhmm_clock_ctrl_if
// Groups the button inputs and the display/time outputs of the HH:MM clock
// controller.
//
// Button protocol: mode_btn and inc_btn are already-debounced, single-cycle
// pulses. They are sampled on the rising clock edge and are never
// back-pressured, so each cycle a button is high counts as one press. When
// both are high on the same edge, mode_btn takes effect and inc_btn is dropped.
//
// Signals:
//   mode_btn  (master->slave) advance the time-set FSM
//   inc_btn   (master->slave) increment the field being edited
//   digit_sel (slave->master) one-hot digit enable, bit0 = minute units
//   dig_val   (slave->master) BCD value of the selected digit
//   colon     (slave->master) colon LED
//   state     (slave->master) 00 RUN, 01 SET_HR, 10 SET_MIN
//   hour_bcd  (slave->master) hours, BCD
//   min_bcd   (slave->master) minutes, BCD
//   pm        (slave->master) PM flag (12 h build only, else 0)
// -----------------------------------------------------------------------------
interface hhmm_clock_ctrl_if;
  logic       mode_btn;
  logic       inc_btn;
  logic [3:0] digit_sel;
  logic [3:0] dig_val;
  logic       colon;
  logic [1:0] state;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic       pm;

  modport master (
    output mode_btn, inc_btn,
    input  digit_sel, dig_val, colon, state, hour_bcd, min_bcd, pm
  );

  modport slave (
    input  mode_btn, inc_btn,
    output digit_sel, dig_val, colon, state, hour_bcd, min_bcd, pm
  );
endinterface

// File: rtl/hhmm_clock_ctrl.sv
// -----------------------------------------------------------------------------
// hhmm_clock_ctrl
// HH:MM digital clock controller. Keeps time in BCD, runs a RUN / SET_HR /
// SET_MIN time-set FSM from two button pulses, and time-multiplexes the four
// digits onto one shared BCD-to-7-segment decoder with blinking of the field
// being edited.
//
// Build option: define FMT12H_EN for 12 h format (hours 01..12, reset 12:00,
// pm toggles on 11 -> 12). Without it the clock is 24 h and pm is tied 0.
//
// Parameters:
//   TICK_DIV  clk cycles per 1 s tick (>= 2)
//   SCAN_DIV  clk cycles per digit scan step (>= 1)
//   BLINK_DIV clk cycles per blink phase toggle (>= 1)
//
// Ports:
//   clk  system clock, all logic on posedge
//   rst  asynchronous, active-low reset
//   bus  hhmm_clock_ctrl_if.slave: buttons in; digit_sel, dig_val, colon,
//        state, hour_bcd, min_bcd, pm out
// -----------------------------------------------------------------------------
module hhmm_clock_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                clk,
  input  logic                rst,
  hhmm_clock_ctrl_if.slave    bus
);

  localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------------
  // Time-set FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (bus.mode_btn) w_state_nxt = ST_SET_HR;
      ST_SET_HR:  if (bus.mode_btn) w_state_nxt = ST_SET_MIN;
      ST_SET_MIN: if (bus.mode_btn) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timekeeping registers (one BCD nibble per digit)
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] r_presc, w_presc_nxt;
  logic [3:0] r_hr_t, r_hr_u, r_mn_t, r_mn_u, r_sc_t, r_sc_u;
  logic [3:0] w_hr_t_nxt, w_hr_u_nxt, w_mn_t_nxt, w_mn_u_nxt, w_sc_t_nxt, w_sc_u_nxt;
  logic [3:0] w_hr_t_inc, w_hr_u_inc, w_mn_t_inc, w_mn_u_inc, w_sc_t_inc, w_sc_u_inc;
  logic       w_sec_wrap, w_min_wrap;

`ifdef FMT12H_EN
  localparam logic [3:0] HR_T_RST = 4'd1;
  localparam logic [3:0] HR_U_RST = 4'd2;
  logic r_pm, w_pm_nxt, w_pm_tog;
`else
  localparam logic [3:0] HR_T_RST = 4'd0;
  localparam logic [3:0] HR_U_RST = 4'd0;
`endif

  // Incremented hour, staying inside the legal BCD range of the build.
  always_comb begin
    w_hr_t_inc = r_hr_t;
    w_hr_u_inc = r_hr_u + 4'd1;
`ifdef FMT12H_EN
    w_pm_tog = (r_hr_t == 4'd1) && (r_hr_u == 4'd1);
    if ((r_hr_t == 4'd1) && (r_hr_u == 4'd2)) begin
      w_hr_t_inc = 4'd0;
      w_hr_u_inc = 4'd1;
    end else if (r_hr_u == 4'd9) begin
      w_hr_t_inc = r_hr_t + 4'd1;
      w_hr_u_inc = 4'd0;
    end
`else
    if ((r_hr_t == 4'd2) && (r_hr_u == 4'd3)) begin
      w_hr_t_inc = 4'd0;
      w_hr_u_inc = 4'd0;
    end else if (r_hr_u == 4'd9) begin
      w_hr_t_inc = r_hr_t + 4'd1;
      w_hr_u_inc = 4'd0;
    end
`endif
  end

  // Incremented minutes and seconds, both wrapping 59 -> 00.
  always_comb begin
    w_min_wrap = (r_mn_t == 4'd5) && (r_mn_u == 4'd9);
    w_mn_t_inc = r_mn_t;
    w_mn_u_inc = r_mn_u + 4'd1;
    if (w_min_wrap) begin
      w_mn_t_inc = 4'd0;
      w_mn_u_inc = 4'd0;
    end else if (r_mn_u == 4'd9) begin
      w_mn_t_inc = r_mn_t + 4'd1;
      w_mn_u_inc = 4'd0;
    end

    w_sec_wrap = (r_sc_t == 4'd5) && (r_sc_u == 4'd9);
    w_sc_t_inc = r_sc_t;
    w_sc_u_inc = r_sc_u + 4'd1;
    if (w_sec_wrap) begin
      w_sc_t_inc = 4'd0;
      w_sc_u_inc = 4'd0;
    end else if (r_sc_u == 4'd9) begin
      w_sc_t_inc = r_sc_t + 4'd1;
      w_sc_u_inc = 4'd0;
    end
  end

  always_comb begin
    w_presc_nxt = r_presc;
    w_hr_t_nxt  = r_hr_t;
    w_hr_u_nxt  = r_hr_u;
    w_mn_t_nxt  = r_mn_t;
    w_mn_u_nxt  = r_mn_u;
    w_sc_t_nxt  = r_sc_t;
    w_sc_u_nxt  = r_sc_u;
`ifdef FMT12H_EN
    w_pm_nxt    = r_pm;
`endif
    case (r_state)
      ST_RUN: begin
        if (bus.mode_btn) begin
          // Leaving for SET_HR: seconds and prescaler restart from zero.
          w_presc_nxt = '0;
          w_sc_t_nxt  = 4'd0;
          w_sc_u_nxt  = 4'd0;
        end else if (r_presc == TICK_W'(TICK_DIV - 1)) begin
          w_presc_nxt = '0;
          w_sc_t_nxt  = w_sc_t_inc;
          w_sc_u_nxt  = w_sc_u_inc;
          if (w_sec_wrap) begin
            w_mn_t_nxt = w_mn_t_inc;
            w_mn_u_nxt = w_mn_u_inc;
            if (w_min_wrap) begin
              w_hr_t_nxt = w_hr_t_inc;
              w_hr_u_nxt = w_hr_u_inc;
`ifdef FMT12H_EN
              w_pm_nxt   = r_pm ^ w_pm_tog;
`endif
            end
          end
        end else begin
          w_presc_nxt = r_presc + TICK_W'(1);
        end
      end
      ST_SET_HR: begin
        w_presc_nxt = '0;
        w_sc_t_nxt  = 4'd0;
        w_sc_u_nxt  = 4'd0;
        if (!bus.mode_btn && bus.inc_btn) begin
          w_hr_t_nxt = w_hr_t_inc;
          w_hr_u_nxt = w_hr_u_inc;
`ifdef FMT12H_EN
          w_pm_nxt   = r_pm ^ w_pm_tog;
`endif
        end
      end
      ST_SET_MIN: begin
        w_presc_nxt = '0;
        w_sc_t_nxt  = 4'd0;
        w_sc_u_nxt  = 4'd0;
        // Minutes wrap without carrying into the hours.
        if (!bus.mode_btn && bus.inc_btn) begin
          w_mn_t_nxt = w_mn_t_inc;
          w_mn_u_nxt = w_mn_u_inc;
        end
      end
      default: begin
        w_presc_nxt = '0;
        w_sc_t_nxt  = 4'd0;
        w_sc_u_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_hr_t  <= HR_T_RST;
      r_hr_u  <= HR_U_RST;
      r_mn_t  <= 4'd0;
      r_mn_u  <= 4'd0;
      r_sc_t  <= 4'd0;
      r_sc_u  <= 4'd0;
`ifdef FMT12H_EN
      r_pm    <= 1'b0;
`endif
    end else begin
      r_presc <= w_presc_nxt;
      r_hr_t  <= w_hr_t_nxt;
      r_hr_u  <= w_hr_u_nxt;
      r_mn_t  <= w_mn_t_nxt;
      r_mn_u  <= w_mn_u_nxt;
      r_sc_t  <= w_sc_t_nxt;
      r_sc_u  <= w_sc_u_nxt;
`ifdef FMT12H_EN
      r_pm    <= w_pm_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan and blink phase (free-running in every state)
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [1:0]         r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [3:0] w_sel;
  logic [3:0] w_dig;

  // The field being edited is blanked by masking its enables only; the value
  // sent to the decoder is left alone.
  always_comb begin
    w_sel = 4'b0001 << r_idx;
    if ((r_state == ST_SET_HR) && r_phase)  w_sel[3:2] = 2'b00;
    if ((r_state == ST_SET_MIN) && r_phase) w_sel[1:0] = 2'b00;
  end

  always_comb begin
    w_dig = r_mn_u;
    case (r_idx)
      2'd0:    w_dig = r_mn_u;
      2'd1:    w_dig = r_mn_t;
      2'd2:    w_dig = r_hr_u;
      default: w_dig = r_hr_t;
    endcase
  end

  assign bus.digit_sel = w_sel;
  assign bus.dig_val   = w_dig;
  assign bus.colon     = (r_state == ST_RUN) ? r_sc_u[0] : 1'b1;
  assign bus.state     = r_state;
  assign bus.hour_bcd  = {r_hr_t, r_hr_u};
  assign bus.min_bcd   = {r_mn_t, r_mn_u};
`ifdef FMT12H_EN
  assign bus.pm        = r_pm;
`else
  assign bus.pm        = 1'b0;
`endif

endmodule

// File: tb/tb_hhmm_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hhmm_clock_ctrl
// Self-checking bench for hhmm_clock_ctrl. A time-of-day model (plain integer
// hours/minutes/seconds plus a cycle count since reset) predicts every output
// and is compared on each falling edge; directed sequences add hand-computed
// literal expectations. Honours FMT12H_EN when defined.
// -----------------------------------------------------------------------------
module tb_hhmm_clock_ctrl;
  localparam int TICK_DIV  = 4;
  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 8;

`ifdef FMT12H_EN
  localparam int         H_RST      = 12;
  localparam logic [7:0] H_RST_BCD  = 8'h12;
`else
  localparam int         H_RST      = 0;
  localparam logic [7:0] H_RST_BCD  = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hhmm_clock_ctrl_if bus();

  hhmm_clock_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: time of day as integers, display derived from cycle count
  // ---------------------------------------------------------------------------
  int m_state, m_h, m_m, m_s, m_pc, m_cyc;
  bit m_pm;
  bit cmp_en = 1'b0;

  task automatic model_hour_inc();
`ifdef FMT12H_EN
    if (m_h == 11) begin
      m_h  = 12;
      m_pm = !m_pm;
    end else if (m_h == 12) m_h = 1;
    else m_h = m_h + 1;
`else
    m_h = (m_h + 1) % 24;
`endif
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_h = H_RST; m_m = 0; m_s = 0; m_pc = 0; m_cyc = 0; m_pm = 0;
    end else begin
      m_cyc = m_cyc + 1;
      case (m_state)
        0: begin
          if (bus.mode_btn) begin
            m_state = 1; m_s = 0; m_pc = 0;
          end else begin
            m_pc = m_pc + 1;
            if (m_pc == TICK_DIV) begin
              m_pc = 0;
              m_s  = m_s + 1;
              if (m_s == 60) begin
                m_s = 0;
                m_m = m_m + 1;
                if (m_m == 60) begin
                  m_m = 0;
                  model_hour_inc();
                end
              end
            end
          end
        end
        1: begin
          if (bus.mode_btn) m_state = 2;
          else if (bus.inc_btn) model_hour_inc();
        end
        default: begin
          if (bus.mode_btn) m_state = 0;
          else if (bus.inc_btn) m_m = (m_m + 1) % 60;
        end
      endcase
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [3:0] exp_sel();
    int idx = (m_cyc / SCAN_DIV) % 4;
    int ph  = (m_cyc / BLINK_DIV) % 2;
    logic [3:0] s = 4'b0001 << idx;
    if (m_state == 1 && ph == 1) s[3:2] = 2'b00;
    if (m_state == 2 && ph == 1) s[1:0] = 2'b00;
    return s;
  endfunction

  function automatic logic [3:0] exp_dig();
    int idx = (m_cyc / SCAN_DIV) % 4;
    case (idx)
      0:       return 4'(m_m % 10);
      1:       return 4'(m_m / 10);
      2:       return 4'(m_h % 10);
      default: return 4'(m_h / 10);
    endcase
  endfunction

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (cmp_en && rst) begin
      chk("m_state", 32'(bus.state), 32'(m_state));
      chk("m_hour", 32'(bus.hour_bcd), 32'(to_bcd(m_h)));
      chk("m_min", 32'(bus.min_bcd), 32'(to_bcd(m_m)));
      chk("m_colon", 32'(bus.colon), (m_state == 0) ? 32'(m_s % 2) : 32'd1);
      chk("m_digit_sel", 32'(bus.digit_sel), 32'(exp_sel()));
      chk("m_dig_val", 32'(bus.dig_val), 32'(exp_dig()));
      chk("m_pm", 32'(bus.pm), 32'(m_pm));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge; return at the next falling edge)
  // ---------------------------------------------------------------------------
  task automatic pulse(input logic m, input logic i);
    bus.mode_btn = m;
    bus.inc_btn  = i;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
  endtask

  task automatic pulse_n(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) pulse(m, i);
  endtask

  task automatic wait_sel(input logic [3:0] v, input string name);
    int n = 0;
    while (bus.digit_sel !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.digit_sel !== v) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting for digit_sel %b, got %b", name, v, bus.digit_sel);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_hour"}, 32'(bus.hour_bcd), 32'(H_RST_BCD));
    chk({tag, "_min"}, 32'(bus.min_bcd), 32'h00);
    chk({tag, "_digit_sel"}, 32'(bus.digit_sel), 32'b0001);
    chk({tag, "_dig_val"}, 32'(bus.dig_val), 32'd0);
    chk({tag, "_colon"}, 32'(bus.colon), 32'd0);
    chk({tag, "_pm"}, 32'(bus.pm), 32'd0);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] scan_sel[8];
  logic [3:0] scan_dig[8];
  int         n_active;

  initial begin
    scan_sel = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    scan_dig = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1};
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Field setting
    pulse(1'b1, 1'b0);
    chk("enter_set_hr", 32'(bus.state), 32'b01);
`ifdef FMT12H_EN
    pulse_n(1'b0, 1'b1, 11);
    chk("hr12_at_11", 32'(bus.hour_bcd), 32'h11);
    chk("pm_at_11", 32'(bus.pm), 32'd0);
    pulse(1'b0, 1'b1);
    chk("hr12_at_12", 32'(bus.hour_bcd), 32'h12);
    chk("pm_after_12", 32'(bus.pm), 32'd1);
`else
    pulse_n(1'b0, 1'b1, 25);
    chk("hr_25_inc", 32'(bus.hour_bcd), 32'h01);
    chk("hr_25_inc_min", 32'(bus.min_bcd), 32'h00);
`endif
    pulse(1'b1, 1'b0);
    chk("enter_set_min", 32'(bus.state), 32'b10);
    pulse_n(1'b0, 1'b1, 61);
    chk("min_61_inc", 32'(bus.min_bcd), 32'h01);
`ifdef FMT12H_EN
    chk("min_61_hr_kept", 32'(bus.hour_bcd), 32'h12);
`else
    chk("min_61_hr_kept", 32'(bus.hour_bcd), 32'h01);
`endif
    pulse(1'b1, 1'b0);
    chk("back_to_run", 32'(bus.state), 32'b00);

    // Simultaneous buttons in SET_HR: mode wins
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    chk("simul_state", 32'(bus.state), 32'b10);
`ifdef FMT12H_EN
    chk("simul_hour", 32'(bus.hour_bcd), 32'h12);
`else
    chk("simul_hour", 32'(bus.hour_bcd), 32'h01);
`endif
    pulse(1'b1, 1'b0);

    // Rollover: set x:59 and run 60 ticks
    pulse(1'b1, 1'b0);
`ifdef FMT12H_EN
    pulse_n(1'b0, 1'b1, 11);
    chk("roll_set_hr", 32'(bus.hour_bcd), 32'h11);
`else
    pulse_n(1'b0, 1'b1, 22);
    chk("roll_set_hr", 32'(bus.hour_bcd), 32'h23);
`endif
    pulse(1'b1, 1'b0);
    pulse_n(1'b0, 1'b1, 58);
    chk("roll_set_min", 32'(bus.min_bcd), 32'h59);
    pulse(1'b1, 1'b0);
    chk("roll_run", 32'(bus.state), 32'b00);
    repeat (59 * TICK_DIV) @(negedge clk);
    chk("tick59_min", 32'(bus.min_bcd), 32'h59);
    chk("tick59_colon", 32'(bus.colon), 32'd1);
    repeat (TICK_DIV) @(negedge clk);
    chk("tick60_min", 32'(bus.min_bcd), 32'h00);
    chk("tick60_colon", 32'(bus.colon), 32'd0);
`ifdef FMT12H_EN
    chk("tick60_hour", 32'(bus.hour_bcd), 32'h12);
    chk("tick60_pm", 32'(bus.pm), 32'd0);
`else
    chk("tick60_hour", 32'(bus.hour_bcd), 32'h00);
`endif

    // Scan at 12:34
    pulse(1'b1, 1'b0);
`ifndef FMT12H_EN
    pulse_n(1'b0, 1'b1, 12);
`endif
    pulse(1'b1, 1'b0);
    pulse_n(1'b0, 1'b1, 34);
    chk("scan_set_hour", 32'(bus.hour_bcd), 32'h12);
    chk("scan_set_min", 32'(bus.min_bcd), 32'h34);
    pulse(1'b1, 1'b0);
    wait_sel(4'b1000, "scan_align_hi");
    wait_sel(4'b0001, "scan_align_lo");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan_sel_%0d", k), 32'(bus.digit_sel), 32'(scan_sel[k]));
      chk($sformatf("scan_dig_%0d", k), 32'(bus.dig_val), 32'(scan_dig[k]));
      @(negedge clk);
    end

    // Blink in SET_HR: hour digits dark for 8 clk, then scanned for 8 clk
    pulse(1'b1, 1'b0);
    wait_sel(4'b1000, "blink_align_hi");
    wait_sel(4'b0001, "blink_align_lo");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("blink_dark_%0d", k), 32'(bus.digit_sel[3:2]), 32'd0);
      @(negedge clk);
    end
    n_active = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.digit_sel[3:2] != 2'b00) n_active++;
      @(negedge clk);
    end
    chk("blink_lit_cycles", 32'(n_active), 32'd4);

    // Asynchronous reset in the middle of SET_MIN
    pulse(1'b1, 1'b0);
    pulse_n(1'b0, 1'b1, 5);
    chk("pre_rst_state", 32'(bus.state), 32'b10);
    chk("pre_rst_min", 32'(bus.min_bcd), 32'h39);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) @(negedge clk);

    finish_run();
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    finish_run();
  end

endmodule
